// File: rtl/decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, decode and the register file/ALU.
// The master modport drives fetch, flush and writeback. The slave modport is the decode stage.
interface decode_stage_if #(
  parameter int INST_W    = 16,
  parameter int REG_SEL_W = 3
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [INST_W-1:0]    in_inst;
  logic                 out_valid;
  logic                 out_ready;
  logic [REG_SEL_W-1:0] sel_a;
  logic [REG_SEL_W-1:0] sel_b;
  logic [REG_SEL_W-1:0] sel_d;
  logic [INST_W-1:0]    data_imm;
  logic [4:0]           alu_op;
  logic                 reg_d_we;
  logic                 is_jump;
  logic                 is_jumpeq;
  logic                 mem_rd;
  logic                 mem_wr;
  logic                 illegal;
  logic                 wb_valid;
  logic [REG_SEL_W-1:0] wb_sel;
  logic                 hazard;

  modport master (
    output flush, in_valid, in_inst, out_ready, wb_valid, wb_sel,
    input  in_ready, out_valid, sel_a, sel_b, sel_d, data_imm, alu_op,
           reg_d_we, is_jump, is_jumpeq, mem_rd, mem_wr, illegal, hazard
  );

  modport slave (
    input  flush, in_valid, in_inst, out_ready, wb_valid, wb_sel,
    output in_ready, out_valid, sel_a, sel_b, sel_d, data_imm, alu_op,
           reg_d_we, is_jump, is_jumpeq, mem_rd, mem_wr, illegal, hazard
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode with a 2-entry output+skid buffer (one-cycle latency, in_ready registered).
// Define DECODE_HAZARD_EN to enable the RAW/WAW pending-write scoreboard.
module decode_stage #(
  parameter int INST_W    = 16,
  parameter int REG_SEL_W = 3
) (
  input logic          clk,
  input logic          reset,
  decode_stage_if.slave bus
);
  localparam int RD_LSB = INST_W - 4 - REG_SEL_W;
  localparam int F_BIT  = RD_LSB - 1;
  localparam int RA_LSB = F_BIT - REG_SEL_W;
  localparam int RB_LSB = RA_LSB - REG_SEL_W;

  logic              out_full, skid_full;
  logic [INST_W-1:0] out_inst, skid_inst;
  logic              in_acc, out_acc, out_free, hold, vld;

  logic [3:0]           op;
  logic [REG_SEL_W-1:0] rd, ra, rb;
  logic                 f, dec_we;

  assign op     = out_inst[INST_W-1 -: 4];
  assign rd     = out_inst[RD_LSB +: REG_SEL_W];
  assign f      = out_inst[F_BIT];
  assign ra     = out_inst[RA_LSB +: REG_SEL_W];
  assign rb     = out_inst[RB_LSB +: REG_SEL_W];
  assign dec_we = !(op == 4'h7 || op[3:2] == 2'b11);

  assign vld      = out_full && !hold;
  assign in_acc   = bus.in_valid && !skid_full;
  assign out_acc  = vld && bus.out_ready;
  assign out_free = !out_full || out_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_full  <= 1'b0;
      skid_full <= 1'b0;
      out_inst  <= '0;
      skid_inst <= '0;
    end else if (bus.flush) begin
      out_full  <= 1'b0;
      skid_full <= 1'b0;
    end else if (out_free) begin
      // Skid always drains first so order is preserved; in_acc cannot coincide with a full skid.
      if (skid_full) begin
        out_inst  <= skid_inst;
        out_full  <= 1'b1;
        skid_full <= 1'b0;
      end else if (in_acc) begin
        out_inst <= bus.in_inst;
        out_full <= 1'b1;
      end else begin
        out_full <= 1'b0;
      end
    end else if (in_acc) begin
      skid_inst <= bus.in_inst;
      skid_full <= 1'b1;
    end
  end

`ifdef DECODE_HAZARD_EN
  localparam int NUM_REGS = 2 ** REG_SEL_W;
  localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [NUM_REGS-1:0] pending, set_mask, clr_mask;
  logic                chk_a, chk_b, chk_d, hit;

  always_comb begin
    chk_a = (op <= 4'h7) || (op >= 4'h9 && op <= 4'hB) || (op == 4'hD);
    chk_b = (op <= 4'h5) || (op == 4'h7) || (op == 4'hD);
    // LOAD merges into rD, register-target JUMP reads rD, and any writer checks WAW.
    chk_d = (op == 4'h8) || (op == 4'hC && !f) || dec_we;
    hit   = (chk_a && pending[ra]) || (chk_b && pending[rb]) || (chk_d && pending[rd]);
  end

  assign hold     = out_full && hit;
  assign set_mask = (out_acc && dec_we) ? (ONE << rd) : '0;
  assign clr_mask = bus.wb_valid ? (ONE << bus.wb_sel) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_mask) | set_mask;
  end
`else
  assign hold = 1'b0;
  wire unused_wb = &{1'b0, bus.wb_valid, bus.wb_sel};
`endif

  assign bus.in_ready  = !skid_full;
  assign bus.out_valid = vld;
  assign bus.hazard    = hold;
  assign bus.sel_a     = ra;
  assign bus.sel_b     = rb;
  assign bus.sel_d     = rd;
  assign bus.data_imm  = {out_inst[INST_W/2-1:0], out_inst[INST_W/2-1:0]};
  assign bus.alu_op    = {op, f};
  assign bus.reg_d_we  = vld && dec_we;
  assign bus.is_jump   = vld && (op == 4'hC);
  assign bus.is_jumpeq = vld && (op == 4'hD);
  assign bus.mem_rd    = vld && (op == 4'h6);
  assign bus.mem_wr    = vld && (op == 4'h7);
  assign bus.illegal   = vld && (op[3:1] == 3'b111);
endmodule
